mem_wb_pipe: RTL

- Parametrised MEM→WB pipeline stage register. Successor to the single-lane MEM/WB register.
- Carries NUM_LANES issue lanes of register-file writeback, plus HI/LO and the LL/SC bit.
- Adds: flush, bubble insertion on upstream stall, the architectural LLbit register with bypass, and a retired-instruction counter.
- Sits between the MEM stage and the register file / HI-LO / LLbit consumers.

---
 rtl/mem_wb_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline stage register for NUM_LANES issue lanes.
// It also carries HI/LO and the LL/SC bit, holds the architectural LLbit
// with a WB-stage bypass, and counts retired instructions.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall[STALL_W-1:0]         pipeline stall vector (this stage = STAGE)
//   flush                      exception flush, clears the stage register
//   cnt_clr                    synchronous clear of retired_cnt
//   mem_*                      MEM-stage results (lane i at [i*W +: W])
//   wb_*                       registered copies of mem_*
//   llbit_out                  current LLbit, bypassing the pending WB update
//   retired_cnt                count of valid instructions loaded into WB
module mem_wb_pipe #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE     = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [STALL_W-1:0]            stall,
  input  logic                          flush,
  input  logic                          cnt_clr,
  input  logic [NUM_LANES-1:0]          mem_valid,
  input  logic [NUM_LANES-1:0]          mem_we,
  input  logic [NUM_LANES*ADDR_W-1:0]   mem_waddr,
  input  logic [NUM_LANES*DATA_W-1:0]   mem_wdata,
  input  logic                          mem_whilo,
  input  logic [DATA_W-1:0]             mem_hi,
  input  logic [DATA_W-1:0]             mem_lo,
  input  logic                          mem_LLbit_we,
  input  logic                          mem_LLbit_value,
  output logic [NUM_LANES-1:0]          wb_valid,
  output logic [NUM_LANES-1:0]          wb_we,
  output logic [NUM_LANES*ADDR_W-1:0]   wb_waddr,
  output logic [NUM_LANES*DATA_W-1:0]   wb_wdata,
  output logic                          wb_whilo,
  output logic [DATA_W-1:0]             wb_hi,
  output logic [DATA_W-1:0]             wb_lo,
  output logic                          wb_LLbit_we,
  output logic                          wb_LLbit_value,
  output logic                          llbit_out,
  output logic [CNT_W-1:0]              retired_cnt
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_e;

  act_e             act;
  logic             llbit_q;
  logic [CNT_W-1:0] inc;

  // One action per edge; flush outranks our own stall bit.
  always_comb begin
    act = ACT_LOAD;
    if (reset)                 act = ACT_RESET;
    else if (flush)            act = ACT_FLUSH;
    else if (stall[STAGE])     act = ACT_HOLD;
    else if (stall[STAGE-1])   act = ACT_BUBBLE;
  end

  // Only instructions actually entering WB are counted.
  always_comb begin
    inc = '0;
    if (act == ACT_LOAD) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        inc = inc + CNT_W'(mem_valid[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    case (act)
      ACT_LOAD: begin
        wb_valid       <= mem_valid;
        wb_we          <= mem_we;
        wb_waddr       <= mem_waddr;
        wb_wdata       <= mem_wdata;
        wb_whilo       <= mem_whilo;
        wb_hi          <= mem_hi;
        wb_lo          <= mem_lo;
        wb_LLbit_we    <= mem_LLbit_we;
        wb_LLbit_value <= mem_LLbit_value;
      end
      ACT_HOLD: ;
      default: begin
        // reset, flush and bubble all present an empty slot
        wb_valid       <= '0;
        wb_we          <= '0;
        wb_waddr       <= '0;
        wb_wdata       <= '0;
        wb_whilo       <= 1'b0;
        wb_hi          <= '0;
        wb_lo          <= '0;
        wb_LLbit_we    <= 1'b0;
        wb_LLbit_value <= 1'b0;
      end
    endcase
  end

  // A flush discards the LL reservation even if WB is committing one now.
  always_ff @(posedge clk) begin
    if (reset || flush) llbit_q <= 1'b0;
    else if (wb_LLbit_we) llbit_q <= wb_LLbit_value;
  end

  always_comb begin
    if (flush)            llbit_out = 1'b0;
    else if (wb_LLbit_we) llbit_out = wb_LLbit_value;
    else                  llbit_out = llbit_q;
  end

  always_ff @(posedge clk) begin
    if (reset)        retired_cnt <= '0;
    else if (cnt_clr) retired_cnt <= inc;
    else              retired_cnt <= retired_cnt + inc;
  end

endmodule
